filter_ctrl: RTL and testbench
==============================

FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 Parameter NPTS, default 32: complex samples per frame; power of two.
REQ-002 Parameter AW, default 5: coefficient address width, log2(NPTS).
REQ-003 Parameter MLAT, default 2: complex-multiplier latency in cycles, ≥1.
REQ-004 Port clk  input  1: single clock; all logic rises on posedge.
REQ-005 Port reset  input  1: asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-006 Port in_valid  input  1: FFT bin present on in_r/in_i.
REQ-007 Port in_sop  input  1: qualifies bin 0 of a frame; meaningful only with in_valid.
REQ-008 Port in_r, in_i  input  16 each: signed FFT bin.
REQ-009 Port in_ready  output  1: controller accepts a bin this cycle.
REQ-010 Port coef_addr  output  AW: bin index to the synchronous coefficient ROMs.
REQ-011 Port coef_en  output  1: ROM read enable.
REQ-012 Port dp_r, dp_i  output  16 each: registered bin, aligned with ROM output to the multiplier.
REQ-013 Port out_valid, out_sop, out_eop  output  1 each: qualify multiplier output.
REQ-014 Port sop_err  output  1: one-cycle pulse on framing error.
REQ-015 Port frame_cnt  output  16: completed frames, unsigned.

Function
REQ-016 A bin is accepted in any cycle with in_valid and in_ready high ("accept").
REQ-017 States: IDLE, RUN, DONE.
- IDLE: in_ready=1; accept with in_sop → RUN, bin index 0.
- RUN: in_ready=1.
- DONE: in_ready=0 for exactly one cycle, then IDLE.
REQ-018 In IDLE, an accept without in_sop is dropped: index unchanged, sop_err pulses next cycle.
REQ-019 Bin index counter: 0 on frame start, +1 per accept in RUN; no change on in_valid low (gaps of any length allowed).
REQ-020 coef_addr = index of the bin being accepted, combinational from state and counter; 0 in IDLE; coef_en = accept.
REQ-021 dp_r/dp_i register in_r/in_i on accept; hold otherwise.
REQ-022 Accept of bin NPTS-1 → DONE; counter wraps to 0; frame_cnt increments the following cycle, wrapping 0xFFFF→0x0000.
REQ-023 in_sop on an accept in RUN at index ≠0:
- sop_err pulses.
- Partial frame abandoned, not counted.
- Bin taken as bin 0 of a new frame; state stays RUN.
REQ-024 Output qualifiers: accept, sop-flag (index 0) and eop-flag (index NPTS-1) enter a shift pipeline of depth 1+MLAT; out_valid/out_sop/out_eop appear exactly 1+MLAT cycles after the accept.
REQ-025 Abandoned bins already in the pipeline still emerge with out_valid; the abandoned frame therefore shows out_sop without out_eop.
REQ-026 No downstream backpressure; the pipeline advances every cycle.
REQ-027 Maximum throughput: NPTS bins per NPTS+1 cycles (one DONE bubble per frame).

Reset
REQ-028 While reset is low:
- state=IDLE, index=0, in_ready=0, coef_en=0, coef_addr=0.
- dp_r=dp_i=0.
- out_valid=out_sop=out_eop=0, sop_err=0, frame_cnt=0.
- Qualifier pipeline cleared.
REQ-029 in_ready goes 1 on the first clk edge after reset deassertion.
REQ-030 Reset asserted mid-frame discards the frame: no out_eop, no frame_cnt increment, no sop_err.

Verification
REQ-031 Back-to-back frames: 3 frames of 32 bins, in_valid constant, MLAT=2:
- in_ready low one cycle after each bin 31.
- out_sop 3 cycles after each bin-0 accept, out_eop 3 cycles after each bin-31 accept.
- frame_cnt=3.
REQ-032 Gapped input: in_valid toggled randomly over one frame → coef_addr steps 0..31 only on accepts; exactly 32 out_valid pulses; frame_cnt=1.
REQ-033 Mid-frame sop: in_sop at bin 10 →
- sop_err one cycle.
- coef_addr restarts at 0.
- 10 orphan out_valid then a full 32-bin frame.
- frame_cnt=1.
REQ-034 Headless data: in_valid without in_sop in IDLE for 5 cycles → 5 sop_err pulses, no out_valid, coef_addr stays 0.
REQ-035 Reset at bin 20: all outputs 0 immediately (asynchronous); after release, a new full frame completes with frame_cnt=1.
REQ-036 Wrap: frame_cnt preloaded 0xFFFF via force → next completed frame gives 0x0000.

Source files
------------

// File: rtl/filter_ctrl_if.sv
// Bin stream, coefficient-ROM and qualifier signals of the filter controller.
// The source side is the master and the controller is the slave.
interface filter_ctrl_if #(
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_sop;
  logic [15:0]   in_r;
  logic [15:0]   in_i;
  logic          in_ready;
  logic [AW-1:0] coef_addr;
  logic          coef_en;
  logic [15:0]   dp_r;
  logic [15:0]   dp_i;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic          sop_err;
  logic [15:0]   frame_cnt;

  modport master (
    output in_valid, in_sop, in_r, in_i,
    input  in_ready, coef_addr, coef_en, dp_r, dp_i,
    input  out_valid, out_sop, out_eop, sop_err, frame_cnt
  );

  modport slave (
    input  in_valid, in_sop, in_r, in_i,
    output in_ready, coef_addr, coef_en, dp_r, dp_i,
    output out_valid, out_sop, out_eop, sop_err, frame_cnt
  );
endinterface

// File: rtl/filter_ctrl.sv
// Frequency-domain filter controller: frames FFT bins, addresses the coefficient
// ROMs and delays the frame qualifiers to line up with the complex multiplier.
module filter_ctrl #(
  parameter int NPTS = 32,
  parameter int AW   = 5,
  parameter int MLAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  filter_ctrl_if.slave bus
);

  localparam int            DEPTH = 1 + MLAT;
  localparam logic [AW-1:0] LAST  = AW'(NPTS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      binIdx_q, binIdx_d;
  logic [AW-1:0]      curIdx;
  logic               readyEn_q;
  logic               sopErr_q, sopErr_d;
  logic [15:0]        frameCnt_q;
  logic [15:0]        dpR_q, dpI_q;
  logic [DEPTH-1:0]   validPipe_q, sopPipe_q, eopPipe_q;
  logic               inReady, accept, startNew, accKept, frameDone;

  // A new frame may start at any accept carrying in_sop, which also abandons a
  // partial frame. Headless bins in IDLE are accepted but never enter the pipe.
  always_comb begin
    state_d   = state_q;
    binIdx_d  = binIdx_q;
    sopErr_d  = 1'b0;
    frameDone = 1'b0;
    inReady   = readyEn_q && (state_q != DONE);
    accept    = bus.in_valid && inReady;
    startNew  = accept && bus.in_sop;
    curIdx    = (state_q == RUN && !startNew) ? binIdx_q : '0;
    accKept   = accept && ((state_q == RUN) || bus.in_sop);

    case (state_q)
      IDLE:    if (accept && !bus.in_sop) sopErr_d = 1'b1;
      RUN:     if (startNew && (binIdx_q != '0)) sopErr_d = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accKept) begin
      if (curIdx == LAST) begin
        state_d   = DONE;
        binIdx_d  = '0;
        frameDone = 1'b1;
      end else begin
        state_d   = RUN;
        binIdx_d  = curIdx + AW'(1);
      end
    end
  end

  // readyEn_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      binIdx_q   <= '0;
      readyEn_q  <= 1'b0;
      sopErr_q   <= 1'b0;
      frameCnt_q <= '0;
      dpR_q      <= '0;
      dpI_q      <= '0;
    end else begin
      state_q   <= state_d;
      binIdx_q  <= binIdx_d;
      readyEn_q <= 1'b1;
      sopErr_q  <= sopErr_d;
      if (frameDone) frameCnt_q <= frameCnt_q + 16'd1;
      if (accept) begin
        dpR_q <= bus.in_r;
        dpI_q <= bus.in_i;
      end
    end
  end

  // The qualifier pipe never stalls, so its outputs trail the accept by DEPTH cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validPipe_q <= '0;
      sopPipe_q   <= '0;
      eopPipe_q   <= '0;
    end else begin
      validPipe_q <= {validPipe_q[DEPTH-2:0], accKept};
      sopPipe_q   <= {sopPipe_q[DEPTH-2:0], accKept && (curIdx == '0)};
      eopPipe_q   <= {eopPipe_q[DEPTH-2:0], accKept && (curIdx == LAST)};
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.coef_en   = accept;
  assign bus.coef_addr = curIdx;
  assign bus.dp_r      = dpR_q;
  assign bus.dp_i      = dpI_q;
  assign bus.out_valid = validPipe_q[DEPTH-1];
  assign bus.out_sop   = sopPipe_q[DEPTH-1];
  assign bus.out_eop   = eopPipe_q[DEPTH-1];
  assign bus.sop_err   = sopErr_q;
  assign bus.frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// Scoreboard bench for filter_ctrl: directed frames push expected qualifiers,
// a negedge monitor pops and compares them as the DUT presents out_valid.
module tb_filter_ctrl;

  localparam int NPTS = 32;
  localparam int LAT  = 3;

  typedef struct {
    int   due;
    logic sop;
    logic eop;
  } exp_t;

  logic        clk;
  logic        reset;
  int          cyc;
  int          checks;
  int          errors;
  int          stimCount;
  exp_t        expQ[$];
  logic [15:0] lastR, lastI;
  logic [15:0] expFrames;
  logic        errPending;
  logic        doneNext;

  filter_ctrl_if #(.AW(5)) bus ();

  filter_ctrl #(.NPTS(NPTS), .AW(5), .MLAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected entry, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("out_valid_unexpected", 32'(bus.out_valid), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_cycle", cyc, e.due);
        checkOutput("out_sop", 32'(bus.out_sop), 32'(e.sop));
        checkOutput("out_eop", 32'(bus.out_eop), 32'(e.eop));
      end
    end else if (expQ.size() != 0 && expQ[0].due <= cyc) begin
      void'(expQ.pop_front());
      checkOutput("out_valid_missing", 32'(bus.out_valid), 32'd1);
    end
  end

  // One bin slot; a DONE bubble left by the previous bin 31 is absorbed first.
  task automatic applyStimulus(input logic v, input logic s, input int addr,
                               input logic kept, input logic err);
    exp_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sop   = s;
    bus.in_r     = 16'(stimCount * 7 + addr);
    bus.in_i     = 16'(16'hA000 ^ stimCount);
    stimCount++;
    #1;
    if (doneNext) begin
      checkOutput("ready_in_done", 32'(bus.in_ready), 32'd0);
      checkOutput("coef_en_in_done", 32'(bus.coef_en), 32'd0);
      checkOutput("frame_cnt", 32'(bus.frame_cnt), 32'(expFrames));
      checkOutput("sop_err", 32'(bus.sop_err), 32'(errPending));
      errPending = 1'b0;
      doneNext   = 1'b0;
      @(negedge clk);
      #1;
    end
    checkOutput("in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("coef_en", 32'(bus.coef_en), 32'(v));
    checkOutput("coef_addr", 32'(bus.coef_addr), addr);
    checkOutput("sop_err", 32'(bus.sop_err), 32'(errPending));
    checkOutput("dp_r", 32'(bus.dp_r), 32'(lastR));
    checkOutput("dp_i", 32'(bus.dp_i), 32'(lastI));
    if (v) begin
      lastR = bus.in_r;
      lastI = bus.in_i;
    end
    if (kept) begin
      e.due = cyc + LAT;
      e.sop = (addr == 0);
      e.eop = (addr == NPTS - 1);
      expQ.push_back(e);
      if (addr == NPTS - 1) begin
        doneNext  = 1'b1;
        expFrames = expFrames + 16'd1;
      end
    end
    errPending = err;
    @(posedge clk);
  endtask

  task automatic sendFrame();
    for (int b = 0; b < NPTS; b++) applyStimulus(1'b1, b == 0, b, 1'b1, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic resetDut();
    #2 reset = 1'b0;
    expQ.delete();
    #1;
    lastR      = '0;
    lastI      = '0;
    expFrames  = '0;
    errPending = 1'b0;
    doneNext   = 1'b0;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_coef_en", 32'(bus.coef_en), 32'd0);
    checkOutput("rst_coef_addr", 32'(bus.coef_addr), 32'd0);
    checkOutput("rst_dp_r", 32'(bus.dp_r), 32'd0);
    checkOutput("rst_dp_i", 32'(bus.dp_i), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_sop", 32'(bus.out_sop), 32'd0);
    checkOutput("rst_out_eop", 32'(bus.out_eop), 32'd0);
    checkOutput("rst_sop_err", 32'(bus.sop_err), 32'd0);
    checkOutput("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("ready_before_edge", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cyc          = 0;
    checks       = 0;
    errors       = 0;
    stimCount    = 0;
    lastR        = '0;
    lastI        = '0;
    expFrames    = '0;
    errPending   = 1'b0;
    doneNext     = 1'b0;
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sop   = 1'b0;
    bus.in_r     = '0;
    bus.in_i     = '0;
    @(posedge clk);
    resetDut();

    // Back-to-back frames with in_valid held high across the DONE bubbles.
    repeat (3) sendFrame();

    // Gapped frame: random idle cycles between bins.
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int b = 0; b < NPTS; b++) begin
      while ($urandom_range(0, 2) == 0) applyStimulus(1'b0, 1'b0, b, 1'b0, 1'b0);
      applyStimulus(1'b1, b == 0, b, 1'b1, 1'b0);
    end

    // Headless bins in IDLE are dropped and flagged.
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Mid-frame sop at bin 10 restarts the frame.
    for (int b = 0; b < 10; b++) applyStimulus(1'b1, b == 0, b, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b1);
    for (int b = 1; b < NPTS; b++) applyStimulus(1'b1, 1'b0, b, 1'b1, 1'b0);

    // Reset at bin 20, then one full frame.
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int b = 0; b < 20; b++) applyStimulus(1'b1, b == 0, b, 1'b1, 1'b0);
    resetDut();
    sendFrame();
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.frameCnt_q = 16'hFFFF;
    #1;
    release dut.frameCnt_q;
    expFrames = 16'hFFFF;
    sendFrame();
    repeat (6) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
